adder_arbiter: RTL
==================

Name: adder_arbiter

Overview:
- Shares one registered W-bit adder (2-cycle input-to-sum latency) between N requesters.
- Per-requester valid/ready request and response channels.
- Round-robin issue of at most one operation per cycle into the adder.
- Tags each issue through a latency-matched pipeline and returns the W+1-bit sum to the owning requester from a per-requester holding register.
- Sits between the datapath clients and the shared adder instance in the lab datapath.

Parameters:
W, 8, operand width; sum is W+1 bits.
N, 4, number of requesters (≥2).
LAT, 2, adder latency in clocks, from operands driven in cycle t to sum valid on add_sum_i in cycle t+LAT.

Ports:
clk  input  1  clock, all state on posedge.
reset  input  1  synchronous, active-high reset.
req_valid_i  input  N  requester i has operands.
req_ready_o  output  N  one-hot grant; handshake = valid & ready.
req_a_i  input  N*W  operand A, requester i at bits [i*W +: W].
req_b_i  input  N*W  operand B, same packing.
rsp_valid_o  output  N  sum held for requester i.
rsp_ready_i  input  N  requester i accepts its sum.
rsp_sum_o  output  N*(W+1)  sum for requester i at [i*(W+1) +: W+1].
add_a_o  output  W  operand A to shared adder.
add_b_o  output  W  operand B to shared adder.
add_sum_i  input  W+1  sum from shared adder.

Behaviour:
- Eligibility: requester i is eligible when req_valid_i[i]=1 and busy[i]=0.
  - busy[i] is a register: set on issue, cleared when its response is consumed (rsp_valid_o[i] & rsp_ready_i[i]).
  - At most one outstanding op per requester.
- Arbitration (combinational from registered state):
  - Search eligible requesters starting at ptr, wrapping modulo N.
  - First hit is granted: req_ready_o one-hot, or all zero when none eligible.
  - On a grant to k, ptr <= (k+1) mod N. Otherwise ptr holds.
- Issue:
  - In the grant cycle, add_a_o/add_b_o = granted requester's operands. Otherwise both are 0.
  - Tag pipeline of LAT stages of {vld, id[$clog2(N)-1:0]} shifts every cycle. Stage 0 is loaded with {grant_any, granted id}.
- Return:
  - When the last tag stage has vld=1, with id j, at cycle t+LAT: rsp_sum[j] <= add_sum_i and rsp_valid[j] <= 1.
  - The response is visible from cycle t+LAT+1.
- Response hold:
  - rsp_valid_o[j] and rsp_sum_o[j] stay stable until rsp_ready_i[j]=1.
  - On consume, rsp_valid <= 0 and busy <= 0.
  - Requester j becomes eligible from the next cycle.
- Latency: issue to rsp_valid_o = LAT+1 cycles (3 by default). Minimum issue-to-issue interval per requester = LAT+2 cycles.
- Aggregate throughput: 1 issue/cycle when ≥LAT+2 requesters are active with responses consumed immediately.
- Simultaneous events:
  - Consume and return for the same requester cannot coincide, because busy prevents a second in-flight op.
  - Returns for different requesters in consecutive cycles are independent.
  - req_valid_i may drop without a grant; no state changes.
- Wrap-around: ptr = N-1 with requester 0 eligible grants 0 and sets ptr to 1.
- Stalled consumer: a requester that never asserts rsp_ready_i blocks only itself. The others continue round-robin.
- Reset (any cycle, including mid-operation) sets:
  - ptr=0, busy=0, all tag vld=0, rsp_valid_o=0, rsp_sum_o=0.
  - req_ready_o=0 during the reset cycle, and add_a_o=add_b_o=0.
  - In-flight adder results are discarded; stale add_sum_i is ignored because the tags are cleared.
- Width: the sum is passed through unmodified as W+1 bits. The arbiter does no arithmetic.

Decomposition:
- Shared package adder_arb_pkg holds the tag struct typedef {logic vld; logic [IDW-1:0] id}, IDW=$clog2(N), and the default constants W_DEF=8, N_DEF=4, LAT_DEF=2.
- One natural sub-module: rr_arbiter (N-bit request and ptr in, one-hot grant and next ptr out), reused by other shared-resource controllers.
- Tag pipeline and response registers stay inline.

Test Plan:
- Single op: after reset, requester 2 sends a=8'd200, b=8'd100.
  - Required: req_ready_o=4'b0100 in cycle 0, add_a_o=200, add_b_o=100.
  - Required: rsp_valid_o[2]=1 in cycle 3 with rsp_sum=9'd300.
  - Required: req_ready_o[2]=0 in cycles 1-3.
- All four requesters valid continuously, responses always ready, operands a=i, b=16*i.
  - Required: grants 0,1,2,3,0,... one per cycle.
  - Required: sums 0,17,34,51 per requester, each arriving 3 cycles after its grant.
- Wrap/priority: ptr=3 (after a grant to 2), only requesters 0 and 3 valid.
  - Required: grant 3, then 0, then 3.
- Back-pressure: requester 1 holds rsp_ready_i=0 for 10 cycles after a=255, b=255.
  - Required: rsp_sum_o[1]=9'd510 stable throughout, with no new grant to 1.
  - Required: requesters 0, 2 and 3 continue to be served.
  - Required: on release, requester 1 is granted again no earlier than the next cycle.
- Reset mid-flight: assert reset the cycle after granting requester 0.
  - Required: no rsp_valid_o in any later cycle.
  - Required: the first grant after reset goes to the lowest-index valid requester.
- Idle: no req_valid_i.
  - Required: req_ready_o=0, add_a_o=add_b_o=0, and rsp_valid_o stays 0 for 20 cycles.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// adder_arb_pkg: shared defaults and the issue-tag type for the adder arbiter
package adder_arb_pkg;
    localparam int W_DEF   = 8;
    localparam int N_DEF   = 4;
    localparam int LAT_DEF = 2;
    localparam int IDW     = $clog2(N_DEF);
    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;
endpackage

// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: requester channels plus the shared-adder operand/sum bus
interface adder_arbiter_if import adder_arb_pkg::*; #(
    parameter int W = W_DEF,
    parameter int N = N_DEF
);
    logic [N-1:0]       req_valid_i;
    logic [N-1:0]       req_ready_o;
    logic [N*W-1:0]     req_a_i;
    logic [N*W-1:0]     req_b_i;
    logic [N-1:0]       rsp_valid_o;
    logic [N-1:0]       rsp_ready_i;
    logic [N*(W+1)-1:0] rsp_sum_o;
    logic [W-1:0]       add_a_o;
    logic [W-1:0]       add_b_o;
    logic [W:0]         add_sum_i;
    modport slave (
        input  req_valid_i, req_a_i, req_b_i, rsp_ready_i, add_sum_i,
        output req_ready_o, rsp_valid_o, rsp_sum_o, add_a_o, add_b_o
    );
    modport master (
        output req_valid_i, req_a_i, req_b_i, rsp_ready_i, add_sum_i,
        input  req_ready_o, rsp_valid_o, rsp_sum_o, add_a_o, add_b_o
    );
endinterface

// File: rtl/adder_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first request at or after ptr, with next pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] id_o,
    output logic                 any_o,
    output logic [$clog2(N)-1:0] ptr_o
);
    localparam int PW = $clog2(N);
    always_comb begin
        gnt_o = '0;
        id_o  = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any_o && req_i[(int'(ptr_i) + k) % N]) begin
                any_o = 1'b1;
                id_o  = PW'((int'(ptr_i) + k) % N);
            end
        end
        gnt_o[id_o] = any_o;
        ptr_o = any_o ? PW'((int'(id_o) + 1) % N) : ptr_i;
    end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one registered adder between N requesters
module adder_arbiter import adder_arb_pkg::*; #(
    parameter int W   = W_DEF,
    parameter int N   = N_DEF,
    parameter int LAT = LAT_DEF
) (
    input logic          clk,
    input logic          reset,
    adder_arbiter_if.slave bus
);
    localparam int PW = $clog2(N);
    logic [PW-1:0]      ptr_q, ptr_d, gnt_id;
    logic [N-1:0]       busy_q, busy_d, rsp_valid_q, rsp_valid_d, elig, gnt, consume;
    logic [N*(W+1)-1:0] rsp_sum_q, rsp_sum_d;
    logic               gnt_any;
    tag_t               tag_q [LAT];
    tag_t               last;
    // Nothing is granted while reset is held, so no issue can leak out of that cycle.
    assign elig = reset ? '0 : bus.req_valid_i & ~busy_q;
    rr_arbiter #(.N(N)) u_rr (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .id_o  (gnt_id),
        .any_o (gnt_any),
        .ptr_o (ptr_d)
    );
    assign bus.req_ready_o = gnt;
    assign bus.add_a_o     = gnt_any ? bus.req_a_i[int'(gnt_id)*W +: W] : '0;
    assign bus.add_b_o     = gnt_any ? bus.req_b_i[int'(gnt_id)*W +: W] : '0;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_sum_o   = rsp_sum_q;
    assign last            = tag_q[LAT-1];
    assign consume         = rsp_valid_q & bus.rsp_ready_i;
    always_comb begin
        busy_d      = (busy_q | gnt) & ~consume;
        rsp_valid_d = rsp_valid_q & ~consume;
        rsp_sum_d   = rsp_sum_q;
        if (last.vld) begin
            rsp_valid_d[last.id]                      = 1'b1;
            rsp_sum_d[int'(last.id)*(W+1) +: W+1] = bus.add_sum_i;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_sum_q   <= '0;
            for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
        end else begin
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            tag_q[0]    <= '{vld: gnt_any, id: IDW'(gnt_id)};
            for (int s = 1; s < LAT; s++) tag_q[s] <= tag_q[s-1];
        end
    end
endmodule
